// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry result buffer feeding the register-file write port.
// Optional sub-word load extension is enabled by defining WB_LOAD_EXTEND_EN.
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    input  logic [4:0]  mem_dest_reg,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [1:0]  mem_load_size,
    input  logic        mem_load_unsigned,
    input  logic [1:0]  mem_addr_lo,
    input  logic        wb_stall,
    output logic        wr_en,
    output logic [4:0]  wr_reg_addr,
    output logic [31:0] wr_data,
    output logic        wb_pending,
    output logic [31:0] retired_count
);
    typedef struct packed {
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t   head_q, head_d, tail_q, tail_d, new_e;
    logic        head_v_q, head_v_d, tail_v_q, tail_v_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] load_ext;
    logic        retire, accept;

`ifdef WB_LOAD_EXTEND_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'(mem_load_data >> {mem_addr_lo, 3'b000});
        ld_half = 16'(mem_load_data >> {mem_addr_lo[1], 4'b0000});
        case (mem_load_size)
            2'b00:   load_ext = mem_load_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = mem_load_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = mem_load_data;
        endcase
    end
`else
    logic unused_load_cfg;
    assign unused_load_cfg = ^{mem_load_size, mem_load_unsigned, mem_addr_lo};
    assign load_ext        = mem_load_data;
`endif

    // Tail is only ever valid while head is valid; a retire shifts tail into head.
    always_comb begin
        retire    = head_v_q & ~wb_stall;
        mem_ready = ~(head_v_q & tail_v_q) | retire;
        accept    = mem_valid & mem_ready;

        new_e.rw   = mem_reg_write;
        new_e.dest = mem_dest_reg;
        new_e.data = mem_mem_to_reg ? load_ext : mem_alu_result;

        head_d    = head_q;
        head_v_d  = head_v_q;
        tail_d    = tail_q;
        tail_v_d  = tail_v_q;
        retired_d = retired_q;

        if (retire) begin
            head_d    = tail_q;
            head_v_d  = tail_v_q;
            tail_v_d  = 1'b0;
            retired_d = retired_q + 32'd1;
        end
        if (accept) begin
            if (!head_v_d) begin
                head_d   = new_e;
                head_v_d = 1'b1;
            end else begin
                tail_d   = new_e;
                tail_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            head_v_q  <= 1'b0;
            tail_v_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            head_v_q  <= head_v_d;
            tail_v_q  <= tail_v_d;
            retired_q <= retired_d;
        end
    end

    assign wr_en         = retire & head_q.rw & (head_q.dest != 5'd0);
    assign wr_reg_addr   = head_v_q ? head_q.dest : 5'd0;
    assign wr_data       = head_v_q ? head_q.data : 32'd0;
    assign wb_pending    = head_v_q;
    assign retired_count = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand-written
// stall/full and reset sequences, then randomized traffic against a queue model.
module tb_writeback_stage;
    logic        clk, reset;
    logic        mem_valid, mem_ready, mem_reg_write, mem_mem_to_reg;
    logic [4:0]  mem_dest_reg;
    logic [31:0] mem_alu_result, mem_load_data;
    logic [1:0]  mem_load_size, mem_addr_lo;
    logic        mem_load_unsigned, wb_stall;
    logic        wr_en, wb_pending;
    logic [4:0]  wr_reg_addr;
    logic [31:0] wr_data, retired_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_cnt;

    writeback_stage dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_dest_reg(mem_dest_reg), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
        .mem_load_unsigned(mem_load_unsigned), .mem_addr_lo(mem_addr_lo),
        .wb_stall(wb_stall), .wr_en(wr_en), .wr_reg_addr(wr_reg_addr),
        .wr_data(wr_data), .wb_pending(wb_pending), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] size,
                         input logic uns, input logic [1:0] lo);
        mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_dest_reg = dest;
        mem_alu_result = alu; mem_load_data = ld; mem_load_size = size;
        mem_load_unsigned = uns; mem_addr_lo = lo;
    endtask

    // Reference load extension from the architectural rule, using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] ld, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lo);
`ifdef WB_LOAD_EXTEND_EN
        longint v;
        int     width;
        if (size == 2'd0) begin
            width = 8;
            v = (longint'(ld) >> (8 * int'(lo))) % 256;
        end else if (size == 2'd1) begin
            width = 16;
            v = (longint'(ld) >> (16 * int'(lo[1]))) % 65536;
        end else begin
            return ld;
        end
        if (!uns && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
        return 32'(v);
`else
        return ld;
`endif
    endfunction

    typedef struct {
        logic        rw, m2r;
        logic [4:0]  dest;
        logic [31:0] alu, ld;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic        exp_en;
        logic [31:0] exp_ext, exp_raw;
    } vec_t;
    vec_t vecs[12];

    typedef struct {
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    initial begin
        vecs[0]  = '{1, 0, 5'd5, 32'h1234,     32'h0,        2'd2, 0, 2'd0, 1, 32'h1234,     32'h1234};
        vecs[1]  = '{1, 0, 5'd0, 32'hDEADBEEF, 32'h0,        2'd2, 0, 2'd0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{0, 0, 5'd7, 32'h55,       32'h0,        2'd2, 0, 2'd0, 0, 32'h55,       32'h55};
        vecs[3]  = '{1, 1, 5'd9, 32'h0,        32'h80F17F00, 2'd0, 0, 2'd1, 1, 32'h0000007F, 32'h80F17F00};
        vecs[4]  = '{1, 1, 5'd9, 32'h0,        32'h80F17F00, 2'd0, 0, 2'd3, 1, 32'hFFFFFF80, 32'h80F17F00};
        vecs[5]  = '{1, 1, 5'd9, 32'h0,        32'h80F17F00, 2'd1, 1, 2'd2, 1, 32'h000080F1, 32'h80F17F00};
        vecs[6]  = '{1, 1, 5'd10, 32'h0,       32'h80F17F00, 2'd1, 0, 2'd0, 1, 32'h00007F00, 32'h80F17F00};
        vecs[7]  = '{1, 1, 5'd11, 32'h0,       32'h80F17F00, 2'd0, 0, 2'd2, 1, 32'hFFFFFFF1, 32'h80F17F00};
        vecs[8]  = '{1, 1, 5'd12, 32'h0,       32'h80F17F00, 2'd3, 1, 2'd1, 1, 32'h80F17F00, 32'h80F17F00};
        vecs[9]  = '{1, 1, 5'd13, 32'h0,       32'h80F17F00, 2'd2, 1, 2'd3, 1, 32'h80F17F00, 32'h80F17F00};
        vecs[10] = '{1, 1, 5'd14, 32'h0,       32'h80F17F00, 2'd1, 0, 2'd2, 1, 32'hFFFF80F1, 32'h80F17F00};
        vecs[11] = '{1, 1, 5'd31, 32'hABCD,    32'h80F17F00, 2'd0, 1, 2'd3, 1, 32'h00000080, 32'h80F17F00};

        reset = 1'b1; wb_stall = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 0, 2'd0);
        #12;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_ready", 32'(mem_ready), 1);
        check("rst_pending", 32'(wb_pending), 0);
        check("rst_count", retired_count, 0);
        check("rst_addr", 32'(wr_reg_addr), 0);
        check("rst_data", wr_data, 0);
        @(negedge clk); reset = 1'b0;
        exp_cnt = 0;

        // Directed single transactions into an empty buffer.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1, vecs[i].rw, vecs[i].m2r, vecs[i].dest, vecs[i].alu, vecs[i].ld,
                  vecs[i].size, vecs[i].uns, vecs[i].lo);
            #1 check($sformatf("v%0d_ready", i), 32'(mem_ready), 1);
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_addr", i), 32'(wr_reg_addr), 32'(vecs[i].dest));
`ifdef WB_LOAD_EXTEND_EN
            check($sformatf("v%0d_data", i), wr_data, vecs[i].exp_ext);
`else
            check($sformatf("v%0d_data", i), wr_data, vecs[i].exp_raw);
`endif
            check($sformatf("v%0d_pending", i), 32'(wb_pending), 1);
            @(negedge clk);
            exp_cnt++;
            #1;
            check($sformatf("v%0d_count", i), retired_count, exp_cnt);
            check($sformatf("v%0d_empty", i), 32'(wb_pending), 0);
        end

        // Stall with three offers: two accepted, then in-order drain while the third enters.
        @(negedge clk);
        wb_stall = 1'b1;
        drive(1, 1, 0, 5'd1, 32'h11, 32'h0, 2'd2, 0, 2'd0);
        @(negedge clk);
        drive(1, 1, 0, 5'd2, 32'h22, 32'h0, 2'd2, 0, 2'd0);
        #1 check("sf_ready_one", 32'(mem_ready), 1);
        @(negedge clk);
        drive(1, 1, 0, 5'd3, 32'h33, 32'h0, 2'd2, 0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("sf_ready_full", 32'(mem_ready), 0);
            check("sf_wr_en_stall", 32'(wr_en), 0);
            check("sf_addr_hold", 32'(wr_reg_addr), 1);
            check("sf_data_hold", wr_data, 32'h11);
            @(negedge clk);
        end
        wb_stall = 1'b0;
        #1;
        check("sf_ready_retire", 32'(mem_ready), 1);
        check("sf_w1_en", 32'(wr_en), 1);
        check("sf_w1_addr", 32'(wr_reg_addr), 1);
        check("sf_w1_data", wr_data, 32'h11);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("sf_w2_en", 32'(wr_en), 1);
        check("sf_w2_addr", 32'(wr_reg_addr), 2);
        check("sf_w2_data", wr_data, 32'h22);
        @(negedge clk);
        #1;
        check("sf_w3_en", 32'(wr_en), 1);
        check("sf_w3_addr", 32'(wr_reg_addr), 3);
        check("sf_w3_data", wr_data, 32'h33);
        @(negedge clk);
        exp_cnt += 3;
        #1;
        check("sf_count", retired_count, exp_cnt);
        check("sf_empty", 32'(wb_pending), 0);

        // Reset with two entries buffered.
        wb_stall = 1'b1;
        drive(1, 1, 0, 5'd4, 32'h44, 32'h0, 2'd2, 0, 2'd0);
        @(negedge clk);
        drive(1, 1, 0, 5'd6, 32'h66, 32'h0, 2'd2, 0, 2'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1 check("mr_full", 32'(mem_ready), 0);
        reset = 1'b1;
        #1;
        check("mr_wr_en", 32'(wr_en), 0);
        check("mr_pending", 32'(wb_pending), 0);
        check("mr_count", retired_count, 0);
        check("mr_ready", 32'(mem_ready), 1);
        @(negedge clk);
        reset = 1'b0; wb_stall = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mr_no_write", 32'(wr_en), 0);
            check("mr_stay_empty", 32'(wb_pending), 0);
            @(negedge clk);
        end

        // Randomized traffic against a queue model of the buffer.
        q.delete();
        for (int i = 0; i < 600; i++) begin
            logic        ex_ready, ex_en;
            logic [4:0]  ex_addr;
            logic [31:0] ex_data;
            ent_t        e;
            drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 5'($urandom % 8), $urandom,
                  $urandom, 2'($urandom), 1'($urandom), 2'($urandom));
            wb_stall = (($urandom % 4) == 0);
            #1;
            ex_ready = (q.size() < 2) || !wb_stall;
            ex_en    = (q.size() > 0) && !wb_stall && q[0].rw && (q[0].dest != 0);
            ex_addr  = (q.size() > 0) ? q[0].dest : 5'd0;
            ex_data  = (q.size() > 0) ? q[0].data : 32'd0;
            check("rnd_ready", 32'(mem_ready), 32'(ex_ready));
            check("rnd_wr_en", 32'(wr_en), 32'(ex_en));
            check("rnd_addr", 32'(wr_reg_addr), 32'(ex_addr));
            check("rnd_data", wr_data, ex_data);
            check("rnd_pending", 32'(wb_pending), 32'(q.size() > 0));
            check("rnd_count", retired_count, exp_cnt);
            if (q.size() > 0 && !wb_stall) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (mem_valid && ex_ready) begin
                e.rw   = mem_reg_write;
                e.dest = mem_dest_reg;
                e.data = mem_mem_to_reg ? ref_load(mem_load_data, mem_load_size,
                                                   mem_load_unsigned, mem_addr_lo)
                                        : mem_alu_result;
                q.push_back(e);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the clock (all state updates on the rising edge), and reset input 1 clears all state immediately when high.
REQ-002 The ports SHALL be:
- mem_valid  input  1  MEM result offered.
- mem_ready  output  1  Block can accept a MEM result.
- mem_reg_write  input  1  Instruction writes a register.
- mem_mem_to_reg  input  1  1 = load data, 0 = ALU result.
- mem_dest_reg  input  5  Destination register.
- mem_alu_result  input  32  ALU result.
- mem_load_data  input  32  Raw load word.
- mem_load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_load_unsigned  input  1  Zero-extend a sub-word load.
- mem_addr_lo  input  2  Byte offset of the load.
- wb_stall  input  1  Hold the writeback this cycle.
- wr_en  output  1  Register file write enable.
- wr_reg_addr  output  5  Register file write address.
- wr_data  output  32  Register file write data.
- wb_pending  output  1  At least one buffered entry.
- retired_count  output  32  Count of retired entries.

Function
REQ-003 Buffer: the block SHALL hold a 2-entry FIFO (head, tail) of {reg_write, dest, data}, with data resolved at accept time.
REQ-004 Handshake: a result SHALL be accepted on a rising edge with mem_valid=1 and mem_ready=1; mem_ready = NOT full, or (full AND head retires this cycle).
REQ-005 Retire: the head SHALL retire on a rising edge when the head is valid and wb_stall=0, including entries with reg_write=0.
REQ-006 Write port: wr_en SHALL be combinational = head_valid AND head_reg_write AND head_dest!=0 AND NOT wb_stall; wr_reg_addr and wr_data SHALL show the head fields whenever the head is valid, and 0 when empty.
REQ-007 Latency: a result accepted into an empty buffer at edge N SHALL appear on wr_* during cycle N+1, and retire at edge N+1 if wb_stall=0.
REQ-008 Throughput: with wb_stall held at 0, the block SHALL sustain one accept and one retire per cycle without mem_ready deasserting.
REQ-009 Simultaneous accept and retire when full: the head SHALL retire, the tail SHALL advance to head, and the new entry SHALL load into tail; the count stays 2.
REQ-010 Simultaneous accept and retire with one entry: the new entry SHALL become head; the count stays 1.
REQ-011 Data select: if mem_mem_to_reg=0, data SHALL be mem_alu_result; otherwise data SHALL be the load-extended word defined under Configuration.
REQ-012 $zero: entries with dest=0 SHALL be buffered and retired and SHALL increment retired_count, but SHALL never assert wr_en.
REQ-013 Stall hold: while wb_stall=1, head contents, wr_reg_addr, and wr_data SHALL stay stable, and wr_en SHALL be 0.
REQ-014 Pending flag: wb_pending SHALL be 1 whenever the entry count is nonzero.
REQ-015 Retire counter: retired_count SHALL increment by 1 per retire and wrap from 0xFFFFFFFF to 0.

Reset
REQ-016 While reset=1, the buffer SHALL be emptied, and wb_pending, wr_en, wr_reg_addr, wr_data, and retired_count SHALL be 0; mem_ready SHALL be 1.
REQ-017 Reset asserted mid-operation SHALL discard all buffered entries without asserting wr_en, and the first edge after release SHALL behave as from empty.

Configuration
REQ-018 With macro WB_LOAD_EXTEND_EN defined, load data SHALL be extended as follows:
- The byte selected by mem_addr_lo, or the half selected by mem_addr_lo[1], is used.
- It is sign-extended, or zero-extended when mem_load_unsigned=1.
- Word loads pass unchanged.
REQ-019 Without WB_LOAD_EXTEND_EN, load data SHALL pass mem_load_data unchanged, and mem_load_size, mem_load_unsigned, and mem_addr_lo SHALL be ignored.

Verification
REQ-020 Single write: accept {reg_write=1, dest=5, alu=0x1234, mem_to_reg=0} -> next cycle wr_en=1, wr_reg_addr=5, wr_data=0x1234; retired_count=1 after the edge.
REQ-021 $zero suppression: accept dest=0, alu=0xDEADBEEF -> wr_en stays 0, and retired_count still increments.
REQ-022 Stall and full: hold wb_stall=1 and offer 3 results -> 2 accepted, mem_ready=0, wr_en=0; release the stall -> writes occur in order, one per cycle, with no loss.
REQ-023 Extension (macro on):
- load_data=0x80F17F00, size=byte, addr_lo=1, signed -> wr_data=0x0000007F.
- addr_lo=3 -> 0xFFFFFF80.
- size=half, addr_lo=2, unsigned -> 0x000080F1.
REQ-024 Extension (macro off): the same load -> wr_data=0x80F17F00.
REQ-025 Reset mid-operation: with 2 entries buffered, pulse reset -> wr_en=0, wb_pending=0, retired_count=0, mem_ready=1 immediately, with no write afterwards.
